sync_fifo_buffer: RTL and testbench
===================================

Name: sync_fifo_buffer

Overview:
- Single-clock synchronous FIFO buffer for byte-wide data between a producer (WRITE strobe) and a consumer (READ strobe).
- Reads are registered: popped data appears on DATA_OUT one cycle after the read is accepted, qualified by a one-cycle Valid pulse.
- Used as the elastic buffer stage in the datapath; FULL/EMPTY status lets the surrounding logic throttle traffic.

Parameters:
- DATA_WIDTH, 8, width of DATA_IN/DATA_OUT in bits.
- DEPTH, 8, number of storage entries; must be a power of two, at least 2.
- ADDR_WIDTH, log2(DEPTH) = 3, pointer width (derived, not overridden).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- DATA_IN  input  DATA_WIDTH  write data.
- WRITE  input  1  push request, sampled at rising CLK.
- READ  input  1  pop request, sampled at rising CLK.
- DATA_OUT  output  DATA_WIDTH  registered read data.
- Valid  output  1  high for exactly the cycle in which DATA_OUT carries newly popped data.
- FULL  output  1  combinational: count == DEPTH.
- EMPTY  output  1  combinational: count == 0.

Behaviour:
- Reset (RESET low, asynchronous, any time including mid-transfer):
  - write pointer, read pointer and count = 0; DATA_OUT = 0; Valid = 0.
  - EMPTY = 1, FULL = 0.
  - Storage contents are not cleared; stale data is never observable because count = 0.
- Internal state: write pointer (ADDR_WIDTH), read pointer (ADDR_WIDTH), count (ADDR_WIDTH+1 bits, range 0..DEPTH). Pointers wrap modulo DEPTH.
- Write accept: wr_ok = WRITE & (~FULL | rd_ok).
  - On wr_ok: mem[wptr] <= DATA_IN; wptr <= wptr+1.
  - WRITE while FULL with no accepted read: ignored; no state change, no data corruption.
- Read accept: rd_ok = READ & ~EMPTY.
  - On rd_ok: DATA_OUT <= mem[rptr]; rptr <= rptr+1; Valid <= 1 on the next edge.
  - Otherwise Valid <= 0 and DATA_OUT holds its previous value.
- Read latency: exactly 1 cycle. No fall-through: a word written in cycle N is readable at the earliest in cycle N+1.
- Count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Simultaneous READ & WRITE:
  - When EMPTY: the write is accepted and the read is ignored (Valid stays 0).
  - When FULL: both are accepted and count stays at DEPTH.
  - Otherwise: both are accepted and count is unchanged.
- Ordering: strict first-in, first-out, including across pointer wrap-around.
- Inputs are assumed synchronous to CLK; no input metastability handling.

Optional Feature:
- Macro FIFO_WATERMARK_EN.
- When defined:
  - Adds parameters AF_LEVEL (default DEPTH-2) and AE_LEVEL (default 2).
  - Adds outputs ALMOST_FULL = (count >= AF_LEVEL) and ALMOST_EMPTY = (count <= AE_LEVEL), both combinational from count.
  - Adds output LEVEL [ADDR_WIDTH:0] = count.
  - After reset: ALMOST_EMPTY = 1, ALMOST_FULL = 0, LEVEL = 0.
- When undefined: these ports and parameters do not exist; core behaviour is identical.

Test Plan:
- Reset: drive RESET=0 mid-stream with 3 words stored, then release -> EMPTY=1, FULL=0, Valid=0, DATA_OUT=0; a subsequent READ yields no Valid pulse.
- Fill/drain: write 0x11,0x22,...,0x88 (8 writes) -> FULL=1 after the 8th edge. Then 8 READs -> DATA_OUT sequence 0x11..0x88, each with Valid high one cycle after its READ; EMPTY=1 after the last.
- Overflow: with FULL=1, WRITE 0xAA with no READ -> ignored; draining returns 0x11..0x88 only.
- Underflow: READ while EMPTY -> Valid stays 0, DATA_OUT unchanged, count stays 0.
- Simultaneous read/write:
  - At 4 entries, READ+WRITE 0x5C for 3 cycles -> count stays 4 and FIFO order is preserved.
  - At FULL, READ+WRITE -> both accepted, FULL remains 1.
  - At EMPTY, READ+WRITE 0x77 -> no Valid that cycle; the next READ returns 0x77.
- Wrap-around: write/read 20 words in interleaved bursts of 5 -> all 20 values come out in order (pointers wrap twice). With FIFO_WATERMARK_EN, ALMOST_FULL asserts when count reaches 6.

Source files
------------

// File: rtl/sync_fifo_buffer.sv
// Single-clock byte FIFO with registered read data and a one-cycle Valid pulse.
// Define FIFO_WATERMARK_EN to add ALMOST_FULL/ALMOST_EMPTY/LEVEL status outputs.
module sync_fifo_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
`ifdef FIFO_WATERMARK_EN
    ,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
`endif
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [DATA_WIDTH-1:0]         DATA_IN,
    input  logic                          WRITE,
    input  logic                          READ,
    output logic [DATA_WIDTH-1:0]         DATA_OUT,
    output logic                          Valid,
`ifdef FIFO_WATERMARK_EN
    output logic                          ALMOST_FULL,
    output logic                          ALMOST_EMPTY,
    output logic [$clog2(DEPTH):0]        LEVEL,
`endif
    output logic                          FULL,
    output logic                          EMPTY
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_ok, rd_ok;

    assign FULL  = (count_q == DEPTH_CNT);
    assign EMPTY = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
    assign rd_ok = READ & ~EMPTY;
    assign wr_ok = WRITE & (~FULL | rd_ok);

    always_comb begin
        count_d = count_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately not reset; count gates every read.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wptr_q] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            DATA_OUT <= '0;
            Valid    <= 1'b0;
        end else begin
            count_q <= count_d;
            Valid   <= rd_ok;
            if (wr_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_q   <= rptr_q + 1'b1;
                DATA_OUT <= mem[rptr_q];
            end
        end
    end

`ifdef FIFO_WATERMARK_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT = AE_LEVEL[ADDR_WIDTH:0];

    assign ALMOST_FULL  = (count_q >= AF_CNT);
    assign ALMOST_EMPTY = (count_q <= AE_CNT);
    assign LEVEL        = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Self-checking bench for sync_fifo_buffer: queue-based reference model compared every
// cycle, plus directed sequences with hand-computed literal expectations.
module tb_sync_fifo_buffer;

    localparam int DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] DATA_IN;
    logic       WRITE;
    logic       READ;
    logic [7:0] DATA_OUT;
    logic       Valid;
    logic       FULL;
    logic       EMPTY;
`ifdef FIFO_WATERMARK_EN
    logic       ALMOST_FULL;
    logic       ALMOST_EMPTY;
    logic [3:0] LEVEL;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_buffer #(
        .DATA_WIDTH(8),
        .DEPTH(DEPTH)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .DATA_IN(DATA_IN),
        .WRITE(WRITE),
        .READ(READ),
        .DATA_OUT(DATA_OUT),
        .Valid(Valid),
`ifdef FIFO_WATERMARK_EN
        .ALMOST_FULL(ALMOST_FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY),
        .LEVEL(LEVEL),
`endif
        .FULL(FULL),
        .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, outputs from the accept rules.
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_valid;
    bit         m_rd, m_wr;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q.delete();
            m_dout  = 8'h00;
            m_valid = 1'b0;
        end else begin
            m_rd    = READ && (q.size() > 0);
            m_wr    = WRITE && ((q.size() < DEPTH) || m_rd);
            m_valid = m_rd;
            if (m_rd) m_dout = q.pop_front();
            if (m_wr) q.push_back(DATA_IN);
        end
    end

    always @(negedge CLK) begin
        check("model_data_out", {24'b0, DATA_OUT}, {24'b0, m_dout});
        check("model_valid", {31'b0, Valid}, {31'b0, m_valid});
        check("model_full", {31'b0, FULL}, {31'b0, q.size() == DEPTH});
        check("model_empty", {31'b0, EMPTY}, {31'b0, q.size() == 0});
`ifdef FIFO_WATERMARK_EN
        check("model_almost_full", {31'b0, ALMOST_FULL}, {31'b0, q.size() >= DEPTH - 2});
        check("model_almost_empty", {31'b0, ALMOST_EMPTY}, {31'b0, q.size() <= 2});
        check("model_level", {28'b0, LEVEL}, q.size());
`endif
    end

    // Apply one cycle of stimulus; returns 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        WRITE   = w;
        READ    = r;
        DATA_IN = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0; WRITE = 1'b0; READ = 1'b0; DATA_IN = 8'h00;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        check("reset_empty", {31'b0, EMPTY}, 32'd1);
        check("reset_full", {31'b0, FULL}, 32'd0);
        check("reset_valid", {31'b0, Valid}, 32'd0);
        check("reset_dout", {24'b0, DATA_OUT}, 32'h0);

        // Fill, overflow, drain
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'((i + 1) * 8'h11));
        check("fill_full", {31'b0, FULL}, 32'd1);
        step(1'b1, 1'b0, 8'hAA);
        check("overflow_full", {31'b0, FULL}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("drain_valid", {31'b0, Valid}, 32'd1);
            check("drain_data", {24'b0, DATA_OUT}, 32'((i + 1) * 8'h11));
        end
        check("drain_empty", {31'b0, EMPTY}, 32'd1);
        step(1'b0, 1'b0, 8'h00);
        check("drain_valid_drop", {31'b0, Valid}, 32'd0);

        // Underflow
        step(1'b0, 1'b1, 8'h00);
        check("underflow_valid", {31'b0, Valid}, 32'd0);
        check("underflow_dout", {24'b0, DATA_OUT}, 32'h88);
        check("underflow_empty", {31'b0, EMPTY}, 32'd1);

        // Simultaneous at empty: write only
        step(1'b1, 1'b1, 8'h77);
        check("rw_empty_valid", {31'b0, Valid}, 32'd0);
        check("rw_empty_notempty", {31'b0, EMPTY}, 32'd0);
        step(1'b0, 1'b1, 8'h00);
        check("rw_empty_read_valid", {31'b0, Valid}, 32'd1);
        check("rw_empty_read_data", {24'b0, DATA_OUT}, 32'h77);

        // Simultaneous at 4 entries
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i));
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b1, 8'h5C);
            check("rw_mid_data", {24'b0, DATA_OUT}, 32'(i));
            check("rw_mid_valid", {31'b0, Valid}, 32'd1);
        end
        check("rw_mid_not_full", {31'b0, FULL}, 32'd0);
        step(1'b0, 1'b1, 8'h00);
        check("rw_mid_drain0", {24'b0, DATA_OUT}, 32'h04);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("rw_mid_drain", {24'b0, DATA_OUT}, 32'h5C);
        end
        check("rw_mid_empty", {31'b0, EMPTY}, 32'd1);

        // Simultaneous at full
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        step(1'b1, 1'b1, 8'hF0);
        check("rw_full_data", {24'b0, DATA_OUT}, 32'h80);
        check("rw_full_valid", {31'b0, Valid}, 32'd1);
        check("rw_full_full", {31'b0, FULL}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("rw_full_drain", {24'b0, DATA_OUT}, 32'(8'h80 + i));
        end
        step(1'b0, 1'b1, 8'h00);
        check("rw_full_last", {24'b0, DATA_OUT}, 32'hF0);

        // Asynchronous reset mid-stream with 3 words stored
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hA1 + i));
        step(1'b0, 1'b0, 8'h00);
        #3 RESET = 1'b0;
        #1;
        check("midreset_empty", {31'b0, EMPTY}, 32'd1);
        check("midreset_full", {31'b0, FULL}, 32'd0);
        check("midreset_valid", {31'b0, Valid}, 32'd0);
        check("midreset_dout", {24'b0, DATA_OUT}, 32'h0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        check("postreset_read_valid", {31'b0, Valid}, 32'd0);

        // Wrap-around: 20 words in bursts of 5
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + b * 5 + i));
            for (int i = 0; i < 5; i++) begin
                step(1'b0, 1'b1, 8'h00);
                check("wrap_data", {24'b0, DATA_OUT}, 32'(8'h30 + b * 5 + i));
            end
        end
        check("wrap_empty", {31'b0, EMPTY}, 32'd1);

`ifdef FIFO_WATERMARK_EN
        check("wm_reset_ae", {31'b0, ALMOST_EMPTY}, 32'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i));
        check("wm_af_at5", {31'b0, ALMOST_FULL}, 32'd0);
        check("wm_ae_at5", {31'b0, ALMOST_EMPTY}, 32'd0);
        step(1'b1, 1'b0, 8'h05);
        check("wm_af_at6", {31'b0, ALMOST_FULL}, 32'd1);
        check("wm_level6", {28'b0, LEVEL}, 32'd6);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00);
        check("wm_level0", {28'b0, LEVEL}, 32'd0);
`endif

        step(1'b0, 1'b0, 8'h00);
        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
